// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - layer sequencer for an in-place 256-point Kyber NTT/INTT
module ntt_ctrl #(
    parameter int WIDTH  = 12,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [7:0]       rd_addr_a,
    output logic [7:0]       rd_addr_b,
    output logic [6:0]       tw_addr,
    input  logic [WIDTH-1:0] rd_data_a,
    input  logic [WIDTH-1:0] rd_data_b,
    input  logic [WIDTH-1:0] tw_data,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    output logic [1:0]       bf_sel,
    input  logic [WIDTH-1:0] bf_c,
    input  logic [WIDTH-1:0] bf_d,
    output logic             wr_en,
    output logic [7:0]       wr_addr_a,
    output logic [7:0]       wr_addr_b,
    output logic [WIDTH-1:0] wr_data_a,
    output logic [WIDTH-1:0] wr_data_b
);

    // total read-to-write delay; also the length of the inter-layer drain
    localparam int PIPE = RD_LAT + BF_LAT;
    localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [DW-1:0] DLAST = DW'(PIPE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic          mode_q;
    logic [2:0]    layer;
    logic [6:0]    idx;
    logic [DW-1:0] dcnt;

    logic [2:0]    lg;
    logic [7:0]    len;
    logic [6:0]    grp;
    logic [6:0]    off;
    logic [7:0]    j;
    logic [6:0]    k;
    logic          run;

    logic [PIPE-1:0] vsr;
    logic [7:0]      asr [PIPE];
    logic [7:0]      bsr [PIPE];

    // sequencer: one butterfly per RUN cycle, then PIPE drain cycles per layer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            layer  <= 3'd0;
            idx    <= 7'd0;
            dcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        layer  <= 3'd0;
                        idx    <= 7'd0;
                        dcnt   <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    idx <= idx + 7'd1;
                    if (idx == 7'd127) begin
                        dcnt  <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dcnt == DLAST) begin
                        dcnt <= '0;
                        if (layer == 3'd6) begin
                            state <= S_DONE;
                        end else begin
                            layer <= layer + 3'd1;
                            idx   <= 7'd0;
                            state <= S_RUN;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // butterfly index -> pair addresses and twiddle index for the current layer
    always_comb begin
        lg  = mode_q ? (layer + 3'd1) : (3'd7 - layer);
        len = 8'd1 << lg;
        grp = idx >> lg;
        off = idx & 7'(len - 8'd1);
        j   = ({1'b0, grp} << ({1'b0, lg} + 4'd1)) | {1'b0, off};
        k   = mode_q ? ((7'd127 >> layer) - grp) : ((7'd1 << layer) + grp);
        run = (state == S_RUN);
    end

    // addresses are held at zero outside RUN so idle buses stay quiet
    always_comb begin
        rd_en     = run;
        rd_addr_a = run ? j : 8'd0;
        rd_addr_b = run ? (j + len) : 8'd0;
        tw_addr   = run ? k : 7'd0;
        busy      = (state == S_RUN) || (state == S_DRAIN);
        done      = (state == S_DONE);
        bf_sel    = busy ? {1'b0, mode_q} : 2'd2;
        bf_a      = rd_data_a;
        bf_b      = rd_data_b;
        bf_w      = tw_data;
        wr_en     = vsr[PIPE-1];
        wr_addr_a = asr[PIPE-1];
        wr_addr_b = bsr[PIPE-1];
        wr_data_a = bf_c;
        wr_data_b = bf_d;
    end

    // write-back delay line: read addresses reappear PIPE cycles later
    always_ff @(posedge clk) begin
        if (!rst) begin
            vsr <= '0;
            for (int s = 0; s < PIPE; s++) begin
                asr[s] <= 8'd0;
                bsr[s] <= 8'd0;
            end
        end else begin
            vsr[0] <= rd_en;
            asr[0] <= rd_addr_a;
            bsr[0] <= rd_addr_b;
            for (int s = 1; s < PIPE; s++) begin
                vsr[s] <= vsr[s-1];
                asr[s] <= asr[s-1];
                bsr[s] <= bsr[s-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb/tb_ntt_ctrl.sv - directed bench for ntt_ctrl with RAM, ROM and butterfly models
module tb_ntt_ctrl;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic        busy, done, rd_en, wr_en;
    logic [7:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0]  tw_addr;
    logic [11:0] rq_a, rq_b, rq_w;
    logic [11:0] bf_a, bf_b, bf_w, bf_c, bf_d, wr_data_a, wr_data_b;
    logic [1:0]  bf_sel;

    int total = 0;
    int bad = 0;

    logic [11:0] ram [0:255];
    logic [11:0] init_mem [0:255];
    logic [11:0] zeta [0:127];
    logic        load_en = 1'b0;
    int          ref_r [0:255];
    int          x0 [0:255];

    logic [7:0]  rec_ra [0:1023];
    logic [7:0]  rec_rb [0:1023];
    logic [6:0]  rec_tw [0:1023];
    logic [7:0]  rec_wa [0:1023];
    logic [7:0]  rec_wb [0:1023];
    logic [1:0]  rec_sel [0:1023];
    logic        rec_en [0:1023];
    logic        rec_we [0:1023];
    logic        rec_done [0:1023];
    logic        rec_busy [0:1023];

    int ia, ib, iw, tt, nc, nd;
    logic [11:0] p1c, p1d, p2c, p2d;

    ntt_ctrl #(.WIDTH(12), .RD_LAT(1), .BF_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .rd_data_a(rq_a), .rd_data_b(rq_b), .tw_data(rq_w),
        .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_sel(bf_sel),
        .bf_c(bf_c), .bf_d(bf_d),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
    );

    always #5 clk = ~clk;

    // ideal butterfly, computed combinationally then delayed two cycles
    always_comb begin
        ia = int'(bf_a); ib = int'(bf_b); iw = int'(bf_w);
        tt = 0; nc = ia; nd = ib;
        if (bf_sel == 2'd0) begin
            tt = (iw * ib) % Q;
            nc = (ia + tt) % Q;
            nd = (ia - tt + Q) % Q;
        end else if (bf_sel == 2'd1) begin
            nc = (ia + ib) % Q;
            nd = (iw * ((ib - ia + Q) % Q)) % Q;
        end
    end

    assign bf_c = p2c;
    assign bf_d = p2d;

    // coefficient RAM, twiddle ROM (1-cycle read) and butterfly pipeline
    always @(posedge clk) begin
        if (load_en) begin
            for (int x = 0; x < 256; x++) ram[x] <= init_mem[x];
        end else if (wr_en) begin
            ram[wr_addr_a] <= wr_data_a;
            ram[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rq_a <= ram[rd_addr_a];
            rq_b <= ram[rd_addr_b];
            rq_w <= zeta[tw_addr];
        end
        p1c <= 12'(nc); p1d <= 12'(nd);
        p2c <= p1c;     p2d <= p1d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_zeta();
        for (int kk = 0; kk < 128; kk++) begin
            int br, z;
            br = 0;
            for (int b = 0; b < 7; b++) if (((kk >> b) & 1) != 0) br = br | (1 << (6 - b));
            z = 1;
            for (int e = 0; e < br; e++) z = (z * 17) % Q;
            zeta[kk] = 12'(z);
        end
    endtask

    task automatic ref_ntt();
        int kz, t;
        kz = 1;
        for (int len = 128; len >= 2; len = len >> 1) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                for (int jj = st; jj < st + len; jj++) begin
                    t = (int'(zeta[kz]) * ref_r[jj + len]) % Q;
                    ref_r[jj + len] = (ref_r[jj] - t + Q) % Q;
                    ref_r[jj] = (ref_r[jj] + t) % Q;
                end
                kz++;
            end
        end
    endtask

    // start one transform and record every output for cycles 1..921
    task automatic run_xform(input logic m, input bit inject, output int wr_cnt, output int rd_cnt);
        wr_cnt = 0; rd_cnt = 0;
        mode = m; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 921; c++) begin
            rec_ra[c] = rd_addr_a; rec_rb[c] = rd_addr_b; rec_tw[c] = tw_addr;
            rec_wa[c] = wr_addr_a; rec_wb[c] = wr_addr_b; rec_sel[c] = bf_sel;
            rec_en[c] = rd_en; rec_we[c] = wr_en; rec_done[c] = done; rec_busy[c] = busy;
            if (wr_en) wr_cnt++;
            if (rd_en) rd_cnt++;
            start = 1'b0; mode = m;
            if (inject && (c == 50 || done)) begin
                start = 1'b1; mode = ~m;
            end
            tick();
        end
        start = 1'b0; mode = m;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; mode = 1'b0;
        tick(); tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_status busy=%b done=%b want 0 0", busy, done); end
        total++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL reset_strobes rd_en=%b wr_en=%b want 0 0", rd_en, wr_en); end
        total++; if ({rd_addr_a, rd_addr_b, tw_addr} !== 23'd0) begin bad++; $display("FAIL reset_rd_addr a=%0d b=%0d k=%0d want 0", rd_addr_a, rd_addr_b, tw_addr); end
        total++; if ({wr_addr_a, wr_addr_b} !== 16'd0) begin bad++; $display("FAIL reset_wr_addr a=%0d b=%0d want 0", wr_addr_a, wr_addr_b); end
        total++; if (bf_sel !== 2'd2) begin bad++; $display("FAIL reset_bf_sel got=%0d want 2", bf_sel); end
        rst = 1'b1; tick();
        rst = 1'b0; start = 1'b1;
        tick();
        rst = 1'b1; start = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL reset_beats_start busy=%b rd_en=%b want 0 0", busy, rd_en); end
    endtask

    task automatic test_ntt();
        int tab [0:11][0:3];
        int wc, rc, nbad, fi;
        tab = '{'{1, 0, 128, 1}, '{2, 1, 129, 1}, '{128, 127, 255, 1}, '{132, 0, 64, 2},
                '{133, 1, 65, 2}, '{196, 128, 192, 3}, '{434, 72, 88, 10}, '{787, 0, 2, 64},
                '{788, 1, 3, 64}, '{789, 4, 6, 65}, '{790, 5, 7, 65}, '{914, 253, 255, 127}};
        for (int x = 0; x < 256; x++) begin
            init_mem[x] = 12'($urandom_range(0, Q - 1));
            x0[x] = int'(init_mem[x]);
            ref_r[x] = x0[x];
        end
        load_en = 1'b1; tick(); load_en = 1'b0;
        ref_ntt();
        run_xform(1'b0, 1'b1, wc, rc);
        for (int e = 0; e < 12; e++) begin
            int c;
            c = tab[e][0];
            total++;
            if ({rec_en[c], rec_ra[c], rec_rb[c], rec_tw[c]} !== {1'b1, 8'(tab[e][1]), 8'(tab[e][2]), 7'(tab[e][3])}) begin
                bad++;
                $display("FAIL ntt_rd cyc=%0d got en=%b a=%0d b=%0d k=%0d want en=1 a=%0d b=%0d k=%0d",
                         c, rec_en[c], rec_ra[c], rec_rb[c], rec_tw[c], tab[e][1], tab[e][2], tab[e][3]);
            end
        end
        total++; if (rec_busy[1] !== 1'b1) begin bad++; $display("FAIL ntt_busy_rise got=%b want 1", rec_busy[1]); end
        total++; if (rec_en[129] !== 1'b0 || rec_en[131] !== 1'b0) begin bad++; $display("FAIL ntt_drain rd_en129=%b rd_en131=%b want 0 0", rec_en[129], rec_en[131]); end
        total++; if (rec_we[3] !== 1'b0) begin bad++; $display("FAIL ntt_wr_early got=%b want 0", rec_we[3]); end
        total++; if ({rec_we[4], rec_wa[4], rec_wb[4]} !== {1'b1, 8'd0, 8'd128}) begin bad++; $display("FAIL ntt_first_wr got en=%b a=%0d b=%0d want 1 0 128", rec_we[4], rec_wa[4], rec_wb[4]); end
        total++; if (rec_we[131] !== 1'b1 || rec_we[132] !== 1'b0) begin bad++; $display("FAIL ntt_layer0_last_wr we131=%b we132=%b want 1 0", rec_we[131], rec_we[132]); end
        total++; if ({rec_we[917], rec_wa[917], rec_wb[917]} !== {1'b1, 8'd253, 8'd255}) begin bad++; $display("FAIL ntt_last_wr got en=%b a=%0d b=%0d want 1 253 255", rec_we[917], rec_wa[917], rec_wb[917]); end
        total++; if (rec_we[918] !== 1'b0) begin bad++; $display("FAIL ntt_wr_after got=%b want 0", rec_we[918]); end
        total++; if (rec_done[917] !== 1'b0 || rec_done[918] !== 1'b1 || rec_done[919] !== 1'b0) begin bad++; $display("FAIL ntt_done 917/918/919 got=%b%b%b want 010", rec_done[917], rec_done[918], rec_done[919]); end
        total++; if (rec_busy[917] !== 1'b1 || rec_busy[918] !== 1'b0) begin bad++; $display("FAIL ntt_busy_fall 917/918 got=%b%b want 10", rec_busy[917], rec_busy[918]); end
        total++; if (rec_busy[919] !== 1'b0 || rec_en[919] !== 1'b0 || rec_busy[920] !== 1'b0) begin bad++; $display("FAIL ntt_start_in_done busy919=%b rd_en919=%b busy920=%b want 0 0 0", rec_busy[919], rec_en[919], rec_busy[920]); end
        total++; if (rec_sel[60] !== 2'd0) begin bad++; $display("FAIL ntt_start_in_run bf_sel=%0d want 0", rec_sel[60]); end
        total++; if (wc != 896 || rc != 896) begin bad++; $display("FAIL ntt_counts writes=%0d reads=%0d want 896 896", wc, rc); end
        nbad = 0; fi = 0;
        for (int x = 0; x < 256; x++) if (int'(ram[x]) != ref_r[x]) begin if (nbad == 0) fi = x; nbad++; end
        total++; if (nbad != 0) begin bad++; $display("FAIL ntt_result %0d wrong, first idx=%0d got=%0d want=%0d", nbad, fi, ram[fi], ref_r[fi]); end
    endtask

    task automatic test_intt();
        int tab [0:5][0:3];
        int wc, rc, nbad, fi, want;
        tab = '{'{1, 0, 2, 127}, '{2, 1, 3, 127}, '{3, 4, 6, 126}, '{128, 253, 255, 64},
                '{434, 72, 88, 13}, '{787, 0, 128, 1}};
        run_xform(1'b1, 1'b0, wc, rc);
        for (int e = 0; e < 6; e++) begin
            int c;
            c = tab[e][0];
            total++;
            if ({rec_en[c], rec_ra[c], rec_rb[c], rec_tw[c]} !== {1'b1, 8'(tab[e][1]), 8'(tab[e][2]), 7'(tab[e][3])}) begin
                bad++;
                $display("FAIL intt_rd cyc=%0d got en=%b a=%0d b=%0d k=%0d want en=1 a=%0d b=%0d k=%0d",
                         c, rec_en[c], rec_ra[c], rec_rb[c], rec_tw[c], tab[e][1], tab[e][2], tab[e][3]);
            end
        end
        total++; if ({rec_ra[914], rec_rb[914], rec_tw[914]} !== {8'd127, 8'd255, 7'd1}) begin bad++; $display("FAIL intt_last_rd got a=%0d b=%0d k=%0d want 127 255 1", rec_ra[914], rec_rb[914], rec_tw[914]); end
        total++; if (rec_sel[5] !== 2'd1) begin bad++; $display("FAIL intt_bf_sel got=%0d want 1", rec_sel[5]); end
        total++; if (rec_done[918] !== 1'b1 || wc != 896) begin bad++; $display("FAIL intt_done done918=%b writes=%0d want 1 896", rec_done[918], wc); end
        nbad = 0; fi = 0; want = 0;
        for (int x = 0; x < 256; x++) if (int'(ram[x]) != (x0[x] * 128) % Q) begin if (nbad == 0) fi = x; nbad++; end
        want = (x0[fi] * 128) % Q;
        total++; if (nbad != 0) begin bad++; $display("FAIL intt_roundtrip %0d wrong, first idx=%0d got=%0d want=%0d", nbad, fi, ram[fi], want); end
    endtask

    task automatic test_reset_mid();
        int wc, rc;
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 434; c++) tick();
        total++; if (rd_addr_a !== 8'd72 || rd_addr_b !== 8'd88) begin bad++; $display("FAIL mid_position a=%0d b=%0d want 72 88", rd_addr_a, rd_addr_b); end
        rst = 1'b0;
        tick();
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL mid_reset_strobes wr_en=%b rd_en=%b want 0 0", wr_en, rd_en); end
        total++; if (busy !== 1'b0 || bf_sel !== 2'd2 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_state busy=%b bf_sel=%0d done=%b want 0 2 0", busy, bf_sel, done); end
        rst = 1'b1;
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_reset_inflight wr_en=%b want 0", wr_en); end
        run_xform(1'b0, 1'b0, wc, rc);
        total++; if (rec_done[918] !== 1'b1 || rec_done[917] !== 1'b0 || wc != 896) begin bad++; $display("FAIL mid_rerun done917=%b done918=%b writes=%0d want 0 1 896", rec_done[917], rec_done[918], wc); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0;
        build_zeta();
        test_reset();
        test_ntt();
        test_intt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

endmodule
